sap_cpu_param: RTL and testbench

- Parametrised next-generation SAP-style accumulator CPU: unified instruction/data RAM, accumulator A, operand register B, carry/zero flags.
- Single-edge (posedge-only) FSM control; no negedge control strobes.
- Adds external program-load port, run/halt control, ready/valid output port with backpressure, logic ops and illegal-opcode trap.
- Sits as the CPU core of the 8-bit computer top level; the output port feeds the display/UART stage.

---
 rtl/sap_cpu_pkg.sv | 59 +++++
 rtl/sap_cpu_alu.sv | 38 +++
 rtl/sap_cpu_param.sv | 219 +++++++++++++++++++++
 tb/tb_sap_cpu_param.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sap_cpu_pkg.sv
// Shared definitions for the SAP-style accumulator CPU: opcodes, FSM states, flags, ALU selects.
// Optional single-step control is enabled with SAP_CPU_SINGLE_STEP_EN.
package sap_cpu_pkg;

    localparam int unsigned OPCODE_W  = 4;
    localparam int unsigned NUM_FLAGS = 2;
    localparam int unsigned FLAG_C    = 0;
    localparam int unsigned FLAG_Z    = 1;

    localparam logic [OPCODE_W-1:0] OP_NOP   = 4'h0;
    localparam logic [OPCODE_W-1:0] OP_LDA   = 4'h1;
    localparam logic [OPCODE_W-1:0] OP_ADD   = 4'h2;
    localparam logic [OPCODE_W-1:0] OP_SUB   = 4'h3;
    localparam logic [OPCODE_W-1:0] OP_STA   = 4'h4;
    localparam logic [OPCODE_W-1:0] OP_LDI   = 4'h5;
    localparam logic [OPCODE_W-1:0] OP_JMP   = 4'h6;
    localparam logic [OPCODE_W-1:0] OP_JC    = 4'h7;
    localparam logic [OPCODE_W-1:0] OP_JZ    = 4'h8;
    localparam logic [OPCODE_W-1:0] OP_AND   = 4'h9;
    localparam logic [OPCODE_W-1:0] OP_OR    = 4'hA;
    localparam logic [OPCODE_W-1:0] OP_XOR   = 4'hB;
    localparam logic [OPCODE_W-1:0] OP_ILL_C = 4'hC;
    localparam logic [OPCODE_W-1:0] OP_ILL_D = 4'hD;
    localparam logic [OPCODE_W-1:0] OP_OUT   = 4'hE;
    localparam logic [OPCODE_W-1:0] OP_HLT   = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_EXEC     = 3'd2,
        ST_OUT_WAIT = 3'd3,
        ST_HALT     = 3'd4
`ifdef SAP_CPU_SINGLE_STEP_EN
        , ST_WAIT_STEP = 3'd5
`endif
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4
    } alu_op_e;

    // Non-ALU opcodes map to ADD; their ALU result is simply not used.
    function automatic alu_op_e alu_op_for(input logic [OPCODE_W-1:0] opcode);
        alu_op_e sel;
        case (opcode)
            OP_SUB:  sel = ALU_SUB;
            OP_AND:  sel = ALU_AND;
            OP_OR:   sel = ALU_OR;
            OP_XOR:  sel = ALU_XOR;
            default: sel = ALU_ADD;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/sap_cpu_alu.sv
// Combinational ALU: add, subtract (C=1 means no borrow), and/or/xor with carry cleared.
module sap_cpu_alu
    import sap_cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_op_e           op_sel,
    output logic [DATA_W-1:0] result,
    output logic              c,
    output logic              z
);

    localparam int unsigned EXT_W = DATA_W + 1;

    logic [DATA_W-1:0] b_inv;
    logic [EXT_W-1:0]  ext;

    assign b_inv = ~b;

    always_comb begin
        ext = '0;
        case (op_sel)
            ALU_ADD: ext = {1'b0, a} + {1'b0, b};
            ALU_SUB: ext = {1'b0, a} + {1'b0, b_inv} + EXT_W'(1);
            ALU_AND: ext = {1'b0, a & b};
            ALU_OR:  ext = {1'b0, a | b};
            ALU_XOR: ext = {1'b0, a ^ b};
            default: ext = '0;
        endcase
    end

    assign result = ext[DATA_W-1:0];
    assign c      = ext[DATA_W];
    assign z      = (ext[DATA_W-1:0] == '0);

endmodule

// File: rtl/sap_cpu_param.sv
// SAP-style accumulator CPU core: unified RAM, program-load port, ready/valid output, illegal trap.
// Defining SAP_CPU_SINGLE_STEP_EN adds a step input and a WAIT_STEP state gating each instruction.
module sap_cpu_param
    import sap_cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
`ifdef SAP_CPU_SINGLE_STEP_EN
    input  logic              step,
`endif
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              halted,
    output logic              illegal,
    output logic [ADDR_W-1:0] pc_dbg
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

`ifdef SAP_CPU_SINGLE_STEP_EN
    localparam state_e ST_NEXT = ST_WAIT_STEP;
`else
    localparam state_e ST_NEXT = ST_FETCH;
`endif

    logic [DATA_W-1:0] mem [DEPTH];

    state_e                state_q, state_d;
    logic [ADDR_W-1:0]     pc_q, pc_d;
    logic [DATA_W-1:0]     a_q, a_d;
    logic [DATA_W-1:0]     b_q, b_d;
    logic [NUM_FLAGS-1:0]  flags_q, flags_d;
    logic [OPCODE_W-1:0]   ir_opcode_q, ir_opcode_d;
    logic [ADDR_W-1:0]     ir_operand_q, ir_operand_d;
    logic [DATA_W-1:0]     out_data_d;
    logic                  out_valid_d;
    logic                  illegal_d;
    logic                  halted_d;

    logic                  ram_we_c;
    logic [ADDR_W-1:0]     ram_waddr_c;
    logic [DATA_W-1:0]     ram_wdata_c;
    logic [DATA_W-1:0]     mem_pc_c;
    logic [DATA_W-1:0]     mem_op_c;

    alu_op_e               alu_op_c;
    logic [DATA_W-1:0]     alu_result;
    logic                  alu_c;
    logic                  alu_z;

`ifdef SAP_CPU_SINGLE_STEP_EN
    logic step_q;
    logic step_go_c;

    // One instruction per rising edge of step, however long the pulse is held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step;
        end
    end

    assign step_go_c = step & ~step_q;
`endif

    assign mem_pc_c = mem[pc_q];
    assign mem_op_c = mem[ir_operand_q];
    assign alu_op_c = alu_op_for(ir_opcode_q);
    assign pc_dbg   = pc_q;

    sap_cpu_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a      (a_q),
        .b      (mem_op_c),
        .op_sel (alu_op_c),
        .result (alu_result),
        .c      (alu_c),
        .z      (alu_z)
    );

    // RAM has no reset so a loaded program survives a CPU reset.
    always_ff @(posedge clk) begin
        if (ram_we_c) begin
            mem[ram_waddr_c] <= ram_wdata_c;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            pc_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            flags_q      <= '0;
            ir_opcode_q  <= '0;
            ir_operand_q <= '0;
            out_data     <= '0;
            out_valid    <= 1'b0;
            illegal      <= 1'b0;
            halted       <= 1'b1;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            a_q          <= a_d;
            b_q          <= b_d;
            flags_q      <= flags_d;
            ir_opcode_q  <= ir_opcode_d;
            ir_operand_q <= ir_operand_d;
            out_data     <= out_data_d;
            out_valid    <= out_valid_d;
            illegal      <= illegal_d;
            halted       <= halted_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        a_d          = a_q;
        b_d          = b_q;
        flags_d      = flags_q;
        ir_opcode_d  = ir_opcode_q;
        ir_operand_d = ir_operand_q;
        out_data_d   = out_data;
        out_valid_d  = out_valid;
        illegal_d    = illegal;
        ram_we_c     = 1'b0;
        ram_waddr_c  = prog_addr;
        ram_wdata_c  = prog_data;

        case (state_q)
            ST_IDLE, ST_HALT: begin
                // Program loading shares the RAM write port with STA; only legal while stopped.
                ram_we_c = prog_we;
                if (run) begin
                    pc_d      = '0;
                    a_d       = '0;
                    flags_d   = '0;
                    illegal_d = 1'b0;
                    state_d   = ST_NEXT;
                end
            end
`ifdef SAP_CPU_SINGLE_STEP_EN
            ST_WAIT_STEP: begin
                if (step_go_c) begin
                    state_d = ST_FETCH;
                end
            end
`endif
            ST_FETCH: begin
                ir_opcode_d  = mem_pc_c[DATA_W-1 -: OPCODE_W];
                ir_operand_d = mem_pc_c[ADDR_W-1:0];
                pc_d         = pc_q + ADDR_W'(1);
                state_d      = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_NEXT;
                case (ir_opcode_q)
                    OP_NOP: begin
                    end
                    OP_LDA: a_d = mem_op_c;
                    OP_LDI: a_d = DATA_W'(ir_operand_q);
                    OP_STA: begin
                        ram_we_c    = 1'b1;
                        ram_waddr_c = ir_operand_q;
                        ram_wdata_c = a_q;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                        b_d             = mem_op_c;
                        a_d             = alu_result;
                        flags_d[FLAG_C] = alu_c;
                        flags_d[FLAG_Z] = alu_z;
                    end
                    OP_JMP: pc_d = ir_operand_q;
                    OP_JC: begin
                        if (flags_q[FLAG_C]) begin
                            pc_d = ir_operand_q;
                        end
                    end
                    OP_JZ: begin
                        if (flags_q[FLAG_Z]) begin
                            pc_d = ir_operand_q;
                        end
                    end
                    OP_OUT: begin
                        out_data_d  = a_q;
                        out_valid_d = 1'b1;
                        state_d     = ST_OUT_WAIT;
                    end
                    OP_HLT: state_d = ST_HALT;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = ST_HALT;
                    end
                endcase
            end
            ST_OUT_WAIT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_NEXT;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        halted_d = (state_d == ST_IDLE) || (state_d == ST_HALT);
    end

endmodule

// File: tb/tb_sap_cpu_param.sv
// Bench for sap_cpu_param: ISA-level reference interpreter plus per-cycle output-port monitor.
module tb_sap_cpu_param;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DEPTH  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              run;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              halted;
    logic              illegal;
    logic [ADDR_W-1:0] pc_dbg;
`ifdef SAP_CPU_SINGLE_STEP_EN
    logic              step;
`endif

    always #5 clk = ~clk;

    sap_cpu_param #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
`ifdef SAP_CPU_SINGLE_STEP_EN
        .step      (step),
`endif
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .halted    (halted),
        .illegal   (illegal),
        .pc_dbg    (pc_dbg)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_xfer = 0;

    logic [7:0] img     [DEPTH];
    logic [7:0] mdl_mem [DEPTH];
    logic [7:0] exp_q   [$];
    logic [3:0] exp_pc;
    logic       exp_illegal;
    logic [7:0] last_xfer;

    bit         hold_v;
    logic [7:0] hold_d;
    logic [3:0] hold_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [3:0] addr, input logic [7:0] data);
        prog_we   = 1'b1;
        prog_addr = addr;
        prog_data = data;
        tick();
        prog_we      = 1'b0;
        mdl_mem[addr] = data;
    endtask

    task automatic clear_img();
        for (int i = 0; i < DEPTH; i++) img[i] = 8'h00;
    endtask

    task automatic load_img();
        for (int i = 0; i < DEPTH; i++) write_word(4'(i), img[i]);
    endtask

    // Instruction-level interpreter: predicts OUT words, final pc and trap state.
    task automatic model_run();
        logic [3:0] pc, opc, opnd;
        logic [7:0] a, m;
        bit         c, z, done;
        int         sum;
        pc = 0; a = 0; c = 0; z = 0; done = 0;
        exp_illegal = 1'b0;
        for (int s = 0; s < 64 && !done; s++) begin
            opc  = mdl_mem[pc][7:4];
            opnd = mdl_mem[pc][3:0];
            m    = mdl_mem[opnd];
            pc   = pc + 4'd1;
            case (opc)
                4'h1: a = m;
                4'h2: begin sum = int'(a) + int'(m); c = (sum > 255); a = 8'(sum); z = (a == 0); end
                4'h3: begin c = (a >= m); a = a - m; z = (a == 0); end
                4'h4: mdl_mem[opnd] = a;
                4'h5: a = {4'h0, opnd};
                4'h6: pc = opnd;
                4'h7: if (c) pc = opnd;
                4'h8: if (z) pc = opnd;
                4'h9: begin a = a & m; c = 0; z = (a == 0); end
                4'hA: begin a = a | m; c = 0; z = (a == 0); end
                4'hB: begin a = a ^ m; c = 0; z = (a == 0); end
                4'hC, 4'hD: begin exp_illegal = 1'b1; done = 1; end
                4'hE: exp_q.push_back(a);
                4'hF: done = 1;
                default: ;
            endcase
        end
        exp_pc = pc;
    endtask

    task automatic start_run();
        run = 1'b1;
        tick();
        run = 1'b0;
        model_run();
    endtask

    task automatic wait_halted(input int budget, output int cycles);
        bit got;
        got = 0;
        cycles = 0;
        while (!got && cycles < budget) begin
            @(negedge clk);
            if (halted) got = 1;
            else cycles++;
        end
        check("halted_reached", halted, 1);
    endtask

    task automatic finish_prog(output int cycles);
        wait_halted(300, cycles);
        check("pc_at_halt", pc_dbg, exp_pc);
        check("illegal_at_halt", illegal, exp_illegal);
        check("outs_pending", exp_q.size(), 0);
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("out_valid_seen", out_valid, 1);
    endtask

    // Output-port monitor: every handshake must match the model, held words must stay put.
    always @(negedge clk) begin
        if (reset) begin
            hold_v = 0;
        end else begin
            if (hold_v) begin
                check("valid_held", out_valid, 1);
                check("data_stable", out_data, hold_d);
                check("pc_stable", pc_dbg, hold_pc);
            end
            if (out_valid && out_ready) begin
                n_xfer++;
                last_xfer = out_data;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_xfer: got word %0h, required no transfer", out_data);
                end else begin
                    check("out_word", out_data, exp_q.pop_front());
                end
                hold_v = 0;
            end else if (out_valid) begin
                hold_v  = 1;
                hold_d  = out_data;
                hold_pc = pc_dbg;
            end else begin
                hold_v = 0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
        $fatal(1);
    end

    initial begin
        int cyc, x0;
        logic [3:0] prev;
        bit saw_wrap;

        reset = 1'b1; run = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        out_ready = 1'b1;
`ifdef SAP_CPU_SINGLE_STEP_EN
        step = 1'b1;
`endif
        for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_halted", halted, 1);
        check("rst_illegal", illegal, 0);
        check("rst_pc", pc_dbg, 0);
        check("rst_out_data", out_data, 0);
        tick();
        reset = 1'b0;

        // LDI 5; ADD F; OUT; HLT with memF=3
        clear_img();
        img[0] = 8'h55; img[1] = 8'h2F; img[2] = 8'hE0; img[3] = 8'hF0; img[15] = 8'h03;
        load_img();
        x0 = n_xfer;
        start_run();
        finish_prog(cyc);
        check("t1_cycles", cyc, 9);
        check("t1_pc_lit", pc_dbg, 4);
        check("t1_word_lit", last_xfer, 8'h08);
        check("t1_xfers", n_xfer - x0, 1);

        // Same program (RAM retained), consumer stalls for 5 cycles
        out_ready = 1'b0;
        x0 = n_xfer;
        start_run();
        wait_valid();
        repeat (5) begin
            @(negedge clk);
            check("t2_valid", out_valid, 1);
            check("t2_data_lit", out_data, 8'h08);
            check("t2_pc_lit", pc_dbg, 3);
        end
        tick();
        out_ready = 1'b1;
        finish_prog(cyc);
        check("t2_xfers", n_xfer - x0, 1);

        // Carry and zero from FF+1: JC and JZ both taken
        clear_img();
        img[0] = 8'h1E; img[1] = 8'h2F; img[2] = 8'h76; img[3] = 8'h57; img[4] = 8'hE0;
        img[5] = 8'hF0; img[6] = 8'h88; img[7] = 8'hF0; img[8] = 8'hE0; img[9] = 8'hF0;
        img[14] = 8'hFF; img[15] = 8'h01;
        load_img();
        start_run();
        finish_prog(cyc);
        check("t3_cycles", cyc, 13);
        check("t3_pc_lit", pc_dbg, 10);
        check("t3_word_lit", last_xfer, 8'h00);

        // 3-5 borrows: JC not taken
        clear_img();
        img[0] = 8'h53; img[1] = 8'h3F; img[2] = 8'h75; img[3] = 8'hE0; img[4] = 8'hF0;
        img[5] = 8'hF0; img[15] = 8'h05;
        load_img();
        start_run();
        finish_prog(cyc);
        check("t4_pc_lit", pc_dbg, 5);
        check("t4_word_lit", last_xfer, 8'hFE);

        // Illegal opcode trap, cleared by the next run
        clear_img();
        img[0] = 8'hC0;
        load_img();
        start_run();
        @(negedge clk);
        check("t5_running", halted, 0);
        repeat (2) @(negedge clk);
        check("t5_halted_2cyc", halted, 1);
        check("t5_illegal_2cyc", illegal, 1);
        check("t5_pc", pc_dbg, exp_pc);
        start_run();
        @(negedge clk);
        check("t5_illegal_cleared", illegal, 0);
        finish_prog(cyc);
        write_word(4'h0, 8'hD0);
        start_run();
        finish_prog(cyc);
        check("t5_d_illegal_lit", illegal, 1);

        // All NOPs: pc walks every address and wraps 15 -> 0
        clear_img();
        load_img();
        start_run();
        @(negedge clk);
        prev = pc_dbg;
        saw_wrap = 0;
        repeat (40) begin
            @(negedge clk);
            if (pc_dbg != prev) begin
                check("t6_pc_step", pc_dbg, 4'(prev + 4'd1));
                if (prev == 4'hF && pc_dbg == 4'h0) saw_wrap = 1;
                prev = pc_dbg;
            end
        end
        check("t6_wrap_seen", saw_wrap, 1);
        check("t6_still_running", halted, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // Reset while waiting on the consumer; RAM must survive
        clear_img();
        img[0] = 8'h55; img[1] = 8'h2F; img[2] = 8'hE0; img[3] = 8'hF0; img[15] = 8'h03;
        load_img();
        out_ready = 1'b0;
        start_run();
        wait_valid();
        tick();
        reset = 1'b1;
        #1;
        check("t7_valid_async", out_valid, 0);
        check("t7_halted", halted, 1);
        check("t7_pc", pc_dbg, 0);
        exp_q.delete();
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        start_run();
        finish_prog(cyc);
        check("t7_word_lit", last_xfer, 8'h08);

        // Program-load writes while running are dropped
        start_run();
        prog_we = 1'b1; prog_addr = 4'hF; prog_data = 8'h40;
        repeat (3) tick();
        prog_we = 1'b0;
        finish_prog(cyc);
        check("t8_word_lit", last_xfer, 8'h08);
        start_run();
        finish_prog(cyc);
        check("t8_rerun_lit", last_xfer, 8'h08);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
